// File: rtl/spi_cmd_pkg.sv
// Shared constants and FSM encoding for the SPI command frame receiver.
package spi_cmd_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] CMD_ROLL_DEF = 8'h41;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPCODE  = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } frame_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall strobes; level is delayed
// one cycle so it lines up with the strobe that describes it.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/spi_cmd_frame_rx.sv
// SPI mode-0 slave that receives opcode+payload frames and hands ROLL payloads
// to a single-entry valid/ready output register.
module spi_cmd_frame_rx
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] CMD_ROLL    = CMD_ROLL_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              roll_valid,
  input  logic              roll_ready,
  output logic [BYTE_W-1:0] roll_data,
  output logic              bad_cmd,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_lvl, sclk_fall, mosi_rise, mosi_fall};

  frame_state_t      state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shift;
  logic [SYNC_STAGES:0] warm;
  logic              armed;
  logic              settled;
  logic              sclk_act;
  logic              byte_done;
  logic              accept;
  logic [BYTE_W-1:0] byte_val;

  // The sync chains start from reset values, not the pin; cs_n is trusted
  // only once real pin samples have filled the whole chain.
  assign settled   = warm[SYNC_STAGES];
  assign sclk_act  = sclk_rise & ~cs_lvl;
  assign byte_done = sclk_act & (bit_cnt == 3'd7);
  assign byte_val  = {shift[BYTE_W-2:0], mosi_lvl};
  assign accept    = roll_valid & roll_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= '0;
      warm       <= '0;
      armed      <= 1'b0;
      roll_valid <= 1'b0;
      roll_data  <= '0;
      bad_cmd    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      bad_cmd   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (settled && cs_lvl) armed <= 1'b1;
      if (accept) roll_valid <= 1'b0;

      if (sclk_act) begin
        shift   <= byte_val;
        bit_cnt <= bit_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state   <= OPCODE;
            bit_cnt <= 3'd0;
          end
        end
        OPCODE: begin
          if (byte_done) begin
            if (byte_val == CMD_ROLL) begin
              state <= PAYLOAD;
            end else begin
              state   <= DISCARD;
              bad_cmd <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (byte_done) begin
            state <= DISCARD;
            if (!roll_valid || accept) begin
              roll_data  <= byte_val;
              roll_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A completed byte in this cycle is handled above before the frame closes.
      if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        case (state)
          OPCODE:  frame_err <= byte_done ? (byte_val == CMD_ROLL) : (bit_cnt != 3'd0);
          PAYLOAD: frame_err <= ~byte_done;
          default: frame_err <= 1'b0;
        endcase
      end
    end
  end

endmodule
